// File: rtl/calc_pkg.sv
// Shared codes for the X/Y/Z register + ULA calculator sequencer.
//   XZ commands : LIMPARXZ / CARREGARXZ / MANTERXZ (2 bits)
//   Y commands  : LIMPARY / CARREGARY / MANTERY / SESQUERDAY / SDIREITAY (3 bits)
//   ULA codes   : SOMAULA / SUBULA (1 bit)
//   opcode_t    : requested operation
//   estado_t    : sequencer states
package calc_pkg;

    localparam logic [1:0] LIMPARXZ   = 2'b00;
    localparam logic [1:0] CARREGARXZ = 2'b01;
    localparam logic [1:0] MANTERXZ   = 2'b10;

    localparam logic [2:0] LIMPARY    = 3'b000;
    localparam logic [2:0] CARREGARY  = 3'b001;
    localparam logic [2:0] MANTERY    = 3'b010;
    localparam logic [2:0] SESQUERDAY = 3'b011;
    localparam logic [2:0] SDIREITAY  = 3'b100;

    localparam logic SOMAULA = 1'b0;
    localparam logic SUBULA  = 1'b1;

    typedef enum logic [1:0] {
        OP_SOMA     = 2'b00,
        OP_SUB      = 2'b01,
        OP_DESL_ESQ = 2'b10,
        OP_DESL_DIR = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARGA_X = 3'd1,
        CARGA_Y = 3'd2,
        DESLOC  = 3'd3,
        EXEC    = 3'd4,
        FIM     = 3'd5
    } estado_t;

endpackage

// File: rtl/contador_desloc.sv
// Loadable down-counter holding the remaining shift count.
//   i_load  : load i_valor (accepted start)
//   i_dec   : decrement by one, saturating at zero
//   i_clear : force to zero (abort); has priority over load/dec
//   o_cnt   : current count
//   o_zero  : count is zero
module contador_desloc #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic         i_clear,
    input  logic [W-1:0] i_valor,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Count register; never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_valor;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sequenciador_calc.sv
// Multi-cycle sequencer driving the X/Y/Z registers and the ULA.
//   iniciar/opcode/qtd : start request, accepted only when idle
//   dado_valido        : operand on the input bus is valid this cycle
//   cancelar           : abort, clears all registers and returns to idle
//   auxX/auxY/auxZ     : per-register commands
//   auxULA             : ULA operation (X op Y)
//   ocupado            : sequencer not idle
//   pronto             : one-cycle completion pulse
// Commands are combinational from state, latched op and dado_valido/cancelar
// so an operand is loaded in the same cycle it is presented.
module sequenciador_calc
    import calc_pkg::*;
#(
    parameter int unsigned SHW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           iniciar,
    input  logic [1:0]     opcode,
    input  logic [SHW-1:0] qtd,
    input  logic           dado_valido,
    input  logic           cancelar,
    output logic [1:0]     auxX,
    output logic [2:0]     auxY,
    output logic [1:0]     auxZ,
    output logic           auxULA,
    output logic           ocupado,
    output logic           pronto
);

    estado_t        r_estado;
    estado_t        w_prox;
    opcode_t        r_op;
    logic           w_load;
    logic           w_dec;
    logic           w_clr;
    logic           w_zero;
    logic           w_desl;
    logic [SHW-1:0] w_cnt;

    // Shift ops are the two codes with the MSB set.
    assign w_desl  = r_op[1];
    assign ocupado = (r_estado != OCIOSO);

    // The counter doubles as the latched shift count.
    contador_desloc #(.W(SHW)) u_contador (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_dec   (w_dec),
        .i_clear (w_clr),
        .i_valor (qtd),
        .o_cnt   (w_cnt),
        .o_zero  (w_zero)
    );

    // State and latched opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
            r_op     <= OP_SOMA;
        end else begin
            r_estado <= w_prox;
            if (w_load) begin
                r_op <= opcode_t'(opcode);
            end
        end
    end

    // Next state and command outputs.
    always_comb begin
        w_prox = r_estado;
        auxX   = MANTERXZ;
        auxY   = MANTERY;
        auxZ   = MANTERXZ;
        auxULA = SOMAULA;
        pronto = 1'b0;
        w_load = 1'b0;
        w_dec  = 1'b0;
        w_clr  = 1'b0;

        if (cancelar) begin
            auxX   = LIMPARXZ;
            auxY   = LIMPARY;
            auxZ   = LIMPARXZ;
            w_clr  = 1'b1;
            w_prox = OCIOSO;
        end else begin
            unique case (r_estado)
                OCIOSO: begin
                    if (iniciar) begin
                        w_load = 1'b1;
                        w_prox = CARGA_X;
                    end
                end
                CARGA_X: begin
                    // Shift ops compute Z = 0 + Y, so X is cleared instead of loaded.
                    if (w_desl) begin
                        auxX   = LIMPARXZ;
                        w_prox = CARGA_Y;
                    end else if (dado_valido) begin
                        auxX   = CARREGARXZ;
                        w_prox = CARGA_Y;
                    end
                end
                CARGA_Y: begin
                    if (dado_valido) begin
                        auxY   = CARREGARY;
                        w_prox = (w_desl && !w_zero) ? DESLOC : EXEC;
                    end
                end
                DESLOC: begin
                    auxY  = (r_op == OP_DESL_ESQ) ? SESQUERDAY : SDIREITAY;
                    w_dec = 1'b1;
                    // Leave after the shift issued with a count of one.
                    if (w_cnt <= SHW'(1)) begin
                        w_prox = EXEC;
                    end
                end
                EXEC: begin
                    auxZ   = CARREGARXZ;
                    auxULA = (r_op == OP_SUB) ? SUBULA : SOMAULA;
                    w_prox = FIM;
                end
                FIM: begin
                    pronto = 1'b1;
                    w_prox = OCIOSO;
                end
                default: begin
                    w_prox = OCIOSO;
                end
            endcase
        end
    end

endmodule
